// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory-bus arbiter.
// Holds the FSM state encoding, bus word width and watchdog width.
package mem_bus_arbiter_pkg;

   localparam int REG_BUS = 32;
   localparam int STALL_W = 6;
   localparam int WDOG_W  = 16;

   localparam logic [REG_BUS-1:0] ZERO_WORD = '0;
   localparam logic [STALL_W-1:0] NO_STALL  = '0;
   localparam logic [3:0]         SEL_WORD  = 4'hF;

   typedef enum logic [2:0] {
      ARB_IDLE     = 3'd0,
      ARB_BUSY_IF  = 3'd1,
      ARB_BUSY_MEM = 3'd2,
      ARB_WAIT_IF  = 3'd3,
      ARB_WAIT_MEM = 3'd4
   } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_bus_watchdog.sv
// Bus-cycle watchdog: counts busy cycles without an acknowledge and flags
// expiry once the count reaches TIMEOUT-1.
module bus_watchdog
   import mem_bus_arbiter_pkg::*;
#(
   parameter logic [WDOG_W-1:0] TIMEOUT = 16'd255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   logic [WDOG_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 16'd1;
      end
   end

   assign expire = (count == (TIMEOUT - 16'd1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates one Wishbone-style bus between instruction fetch and the MEM stage,
// returning read data and raising per-stage stall requests to the controller.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter logic [WDOG_W-1:0] TIMEOUT = 16'd255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [STALL_W-1:0] stall,
   input  logic               flush,
   input  logic               if_ce_i,
   input  logic [REG_BUS-1:0] if_addr_i,
   output logic [REG_BUS-1:0] if_data_o,
   output logic               if_stallreq_o,
   input  logic               mem_ce_i,
   input  logic               mem_we_i,
   input  logic [3:0]         mem_sel_i,
   input  logic [REG_BUS-1:0] mem_addr_i,
   input  logic [REG_BUS-1:0] mem_data_i,
   output logic [REG_BUS-1:0] mem_data_o,
   output logic               mem_stallreq_o,
   output logic               bus_cyc_o,
   output logic               bus_stb_o,
   output logic               bus_we_o,
   output logic [3:0]         bus_sel_o,
   output logic [REG_BUS-1:0] bus_addr_o,
   output logic [REG_BUS-1:0] bus_data_o,
   input  logic [REG_BUS-1:0] bus_data_i,
   input  logic               bus_ack_i,
   output logic               bus_timeout_o
);

   arb_state_t         state;
   logic               flush_pending;
   logic [REG_BUS-1:0] if_data_q;
   logic [REG_BUS-1:0] mem_data_q;

   logic               busy;
   logic               wd_expire;
   logic               term;
   logic               timed_out;
   logic               drop;
   logic [REG_BUS-1:0] rd_data;

   assign busy      = (state == ARB_BUSY_IF) || (state == ARB_BUSY_MEM);
   assign term      = busy && (bus_ack_i || wd_expire);
   assign timed_out = busy && wd_expire && !bus_ack_i;
   assign drop      = flush_pending || flush;
   // Stores and forced terminations both hand back a zero word.
   assign rd_data   = (bus_ack_i && !bus_we_o) ? bus_data_i : ZERO_WORD;

   bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .clear  (!busy),
      .enable (busy && !bus_ack_i),
      .expire (wd_expire)
   );

   always_comb begin
      if_stallreq_o  = 1'b0;
      mem_stallreq_o = 1'b0;
      if_data_o      = ZERO_WORD;
      mem_data_o     = ZERO_WORD;
      case (state)
         ARB_IDLE: begin
            if_stallreq_o  = if_ce_i && !flush;
            mem_stallreq_o = mem_ce_i && !flush;
         end
         ARB_BUSY_IF: begin
            if_stallreq_o  = !term;
            mem_stallreq_o = mem_ce_i;
            if (term && !drop) if_data_o = rd_data;
         end
         ARB_BUSY_MEM: begin
            mem_stallreq_o = !term;
            if_stallreq_o  = if_ce_i;
            if (term && !drop) mem_data_o = rd_data;
         end
         ARB_WAIT_IF: begin
            if_data_o      = if_data_q;
            mem_stallreq_o = mem_ce_i;
         end
         ARB_WAIT_MEM: begin
            mem_data_o    = mem_data_q;
            if_stallreq_o = if_ce_i;
         end
         default: begin
            if_stallreq_o  = 1'b0;
            mem_stallreq_o = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ARB_IDLE;
         flush_pending <= 1'b0;
         if_data_q     <= ZERO_WORD;
         mem_data_q    <= ZERO_WORD;
         bus_cyc_o     <= 1'b0;
         bus_stb_o     <= 1'b0;
         bus_we_o      <= 1'b0;
         bus_sel_o     <= 4'h0;
         bus_addr_o    <= ZERO_WORD;
         bus_data_o    <= ZERO_WORD;
         bus_timeout_o <= 1'b0;
      end else begin
         bus_timeout_o <= timed_out;
         case (state)
            ARB_IDLE: begin
               flush_pending <= 1'b0;
               if (!flush && mem_ce_i) begin
                  bus_cyc_o  <= 1'b1;
                  bus_stb_o  <= 1'b1;
                  bus_we_o   <= mem_we_i;
                  bus_sel_o  <= mem_sel_i;
                  bus_addr_o <= mem_addr_i;
                  bus_data_o <= mem_data_i;
                  state      <= ARB_BUSY_MEM;
               end else if (!flush && if_ce_i) begin
                  bus_cyc_o  <= 1'b1;
                  bus_stb_o  <= 1'b1;
                  bus_we_o   <= 1'b0;
                  bus_sel_o  <= SEL_WORD;
                  bus_addr_o <= if_addr_i;
                  bus_data_o <= ZERO_WORD;
                  state      <= ARB_BUSY_IF;
               end
            end
            ARB_BUSY_IF, ARB_BUSY_MEM: begin
               if (term) begin
                  bus_cyc_o     <= 1'b0;
                  bus_stb_o     <= 1'b0;
                  bus_we_o      <= 1'b0;
                  bus_sel_o     <= 4'h0;
                  bus_addr_o    <= ZERO_WORD;
                  bus_data_o    <= ZERO_WORD;
                  flush_pending <= 1'b0;
                  if (drop || (stall == NO_STALL)) begin
                     state <= ARB_IDLE;
                  end else if (state == ARB_BUSY_IF) begin
                     if_data_q <= rd_data;
                     state     <= ARB_WAIT_IF;
                  end else begin
                     mem_data_q <= rd_data;
                     state      <= ARB_WAIT_MEM;
                  end
               end else if (flush) begin
                  // The cycle already on the bus must finish; only its result is dropped.
                  flush_pending <= 1'b1;
               end
            end
            ARB_WAIT_IF, ARB_WAIT_MEM: begin
               if ((stall == NO_STALL) || flush) state <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a transaction-level model is checked every
// cycle, and literal expectations pin the key points of each scenario.
module tb_mem_bus_arbiter;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  stall;
   logic        flush;
   logic        if_ce_i;
   logic [31:0] if_addr_i;
   logic [31:0] if_data_o;
   logic        if_stallreq_o;
   logic        mem_ce_i;
   logic        mem_we_i;
   logic [3:0]  mem_sel_i;
   logic [31:0] mem_addr_i;
   logic [31:0] mem_data_i;
   logic [31:0] mem_data_o;
   logic        mem_stallreq_o;
   logic        bus_cyc_o;
   logic        bus_stb_o;
   logic        bus_we_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_addr_o;
   logic [31:0] bus_data_o;
   logic [31:0] bus_data_i;
   logic        bus_ack_i;
   logic        bus_timeout_o;

   int total = 0;
   int bad   = 0;

   // Model: one outstanding transaction record and one held-result record.
   logic        m_txn = 1'b0;
   logic        m_txn_mem = 1'b0;
   logic        m_txn_we = 1'b0;
   logic        m_txn_flushed = 1'b0;
   logic [3:0]  m_sel = 4'h0;
   logic [31:0] m_addr = 32'h0;
   logic [31:0] m_wdata = 32'h0;
   int          m_age = 0;
   logic        m_hold = 1'b0;
   logic        m_hold_mem = 1'b0;
   logic [31:0] m_hold_data = 32'h0;
   logic        m_to = 1'b0;

   mem_bus_arbiter #(.TIMEOUT(16'd16)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .flush          (flush),
      .if_ce_i        (if_ce_i),
      .if_addr_i      (if_addr_i),
      .if_data_o      (if_data_o),
      .if_stallreq_o  (if_stallreq_o),
      .mem_ce_i       (mem_ce_i),
      .mem_we_i       (mem_we_i),
      .mem_sel_i      (mem_sel_i),
      .mem_addr_i     (mem_addr_i),
      .mem_data_i     (mem_data_i),
      .mem_data_o     (mem_data_o),
      .mem_stallreq_o (mem_stallreq_o),
      .bus_cyc_o      (bus_cyc_o),
      .bus_stb_o      (bus_stb_o),
      .bus_we_o       (bus_we_o),
      .bus_sel_o      (bus_sel_o),
      .bus_addr_o     (bus_addr_o),
      .bus_data_o     (bus_data_o),
      .bus_data_i     (bus_data_i),
      .bus_ack_i      (bus_ack_i),
      .bus_timeout_o  (bus_timeout_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Compare every DUT output with the model, at the falling edge.
   task automatic sample();
      logic        ending, drop, e_if_s, e_mem_s;
      logic [31:0] rd, e_if_d, e_mem_d;
      @(negedge clk);
      ending  = m_txn && (bus_ack_i || (m_age == TO - 1));
      drop    = m_txn_flushed || flush;
      rd      = (bus_ack_i && !m_txn_we) ? bus_data_i : 32'h0;
      e_if_s  = if_ce_i && !flush;
      e_mem_s = mem_ce_i && !flush;
      e_if_d  = 32'h0;
      e_mem_d = 32'h0;
      if (m_txn) begin
         if (m_txn_mem) begin
            e_mem_s = !ending;
            e_if_s  = if_ce_i;
            if (ending && !drop) e_mem_d = rd;
         end else begin
            e_if_s  = !ending;
            e_mem_s = mem_ce_i;
            if (ending && !drop) e_if_d = rd;
         end
      end else if (m_hold) begin
         if (m_hold_mem) begin
            e_mem_s = 1'b0;
            e_if_s  = if_ce_i;
            e_mem_d = m_hold_data;
         end else begin
            e_if_s  = 1'b0;
            e_mem_s = mem_ce_i;
            e_if_d  = m_hold_data;
         end
      end
      chk("m_cyc",      32'(bus_cyc_o),      32'(m_txn));
      chk("m_stb",      32'(bus_stb_o),      32'(m_txn));
      chk("m_we",       32'(bus_we_o),       32'(m_txn && m_txn_we));
      chk("m_sel",      32'(bus_sel_o),      m_txn ? 32'(m_sel) : 32'h0);
      chk("m_addr",     bus_addr_o,          m_txn ? m_addr : 32'h0);
      chk("m_wdata",    bus_data_o,          m_txn ? m_wdata : 32'h0);
      chk("m_timeout",  32'(bus_timeout_o),  32'(m_to));
      chk("m_if_stall", 32'(if_stallreq_o),  32'(e_if_s));
      chk("m_mem_stall",32'(mem_stallreq_o), 32'(e_mem_s));
      chk("m_if_data",  if_data_o,           e_if_d);
      chk("m_mem_data", mem_data_o,          e_mem_d);
   endtask

   // Advance the model by one clock using the inputs of the current cycle.
   task automatic advance();
      logic        ending, drop;
      logic [31:0] rd;
      ending = m_txn && (bus_ack_i || (m_age == TO - 1));
      drop   = m_txn_flushed || flush;
      rd     = (bus_ack_i && !m_txn_we) ? bus_data_i : 32'h0;
      if (rst) begin
         m_txn = 1'b0;
         m_hold = 1'b0;
         m_to = 1'b0;
      end else begin
         m_to = m_txn && !bus_ack_i && (m_age == TO - 1);
         if (m_txn) begin
            if (ending) begin
               m_txn = 1'b0;
               if (!drop && (stall != 6'd0)) begin
                  m_hold      = 1'b1;
                  m_hold_mem  = m_txn_mem;
                  m_hold_data = rd;
               end
            end else begin
               m_age++;
               if (flush) m_txn_flushed = 1'b1;
            end
         end else if (m_hold) begin
            if ((stall == 6'd0) || flush) m_hold = 1'b0;
         end else if (!flush && (mem_ce_i || if_ce_i)) begin
            m_txn         = 1'b1;
            m_txn_mem     = mem_ce_i;
            m_txn_we      = mem_ce_i && mem_we_i;
            m_sel         = mem_ce_i ? mem_sel_i : 4'hF;
            m_addr        = mem_ce_i ? mem_addr_i : if_addr_i;
            m_wdata       = mem_ce_i ? mem_data_i : 32'h0;
            m_age         = 0;
            m_txn_flushed = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; stall = 6'd0; flush = 1'b0;
      if_ce_i = 1'b0; if_addr_i = 32'h0;
      mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = 4'h0; mem_addr_i = 32'h0; mem_data_i = 32'h0;
      bus_data_i = 32'h0; bus_ack_i = 1'b0;
      advance();
      advance();
      rst = 1'b0;
      sample();
      chk("rst_cyc", 32'(bus_cyc_o), 32'h0);
      chk("rst_if_data", if_data_o, 32'h0);
      chk("rst_mem_stall", 32'(mem_stallreq_o), 32'h0);
      advance();

      // Plain fetch, ack two cycles after cyc rises
      if_ce_i = 1'b1; if_addr_i = 32'h100;
      sample(); chk("t1_stall_idle", 32'(if_stallreq_o), 32'h1); advance();
      sample();
      chk("t1_addr", bus_addr_o, 32'h100);
      chk("t1_sel", 32'(bus_sel_o), 32'hF);
      chk("t1_we", 32'(bus_we_o), 32'h0);
      chk("t1_stall_busy", 32'(if_stallreq_o), 32'h1);
      advance();
      sample(); advance();
      bus_ack_i = 1'b1; bus_data_i = 32'h3C010010;
      sample();
      chk("t1_data", if_data_o, 32'h3C010010);
      chk("t1_stall_ack", 32'(if_stallreq_o), 32'h0);
      advance();
      bus_ack_i = 1'b0; bus_data_i = 32'h0; if_ce_i = 1'b0;
      sample(); chk("t1_cyc_done", 32'(bus_cyc_o), 32'h0); advance();

      // Simultaneous requests: MEM store first, then the fetch
      if_ce_i = 1'b1; if_addr_i = 32'h104;
      mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'hF; mem_addr_i = 32'h80; mem_data_i = 32'hDEADBEEF;
      sample(); advance();
      bus_ack_i = 1'b1; bus_data_i = 32'h55AA55AA;
      sample();
      chk("t2_we", 32'(bus_we_o), 32'h1);
      chk("t2_addr", bus_addr_o, 32'h80);
      chk("t2_wdata", bus_data_o, 32'hDEADBEEF);
      chk("t2_if_stall", 32'(if_stallreq_o), 32'h1);
      chk("t2_store_data", mem_data_o, 32'h0);
      advance();
      bus_ack_i = 1'b0; mem_ce_i = 1'b0; mem_we_i = 1'b0;
      sample(); chk("t2_gap", 32'(bus_cyc_o), 32'h0); advance();
      sample();
      chk("t2_if_cyc", 32'(bus_cyc_o), 32'h1);
      chk("t2_if_addr", bus_addr_o, 32'h104);
      advance();
      bus_ack_i = 1'b1; bus_data_i = 32'h00000013;
      sample(); chk("t2_if_data", if_data_o, 32'h13); advance();
      bus_ack_i = 1'b0; if_ce_i = 1'b0;
      sample(); advance();

      // Fetch acked under stall: result held, no reissue while waiting
      if_ce_i = 1'b1; if_addr_i = 32'h200;
      sample(); advance();
      bus_ack_i = 1'b1; bus_data_i = 32'h12345678; stall = 6'b000111;
      sample(); chk("t3_bypass", if_data_o, 32'h12345678); advance();
      bus_ack_i = 1'b0; bus_data_i = 32'hFFFFFFFF;
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("t3_hold", if_data_o, 32'h12345678);
         chk("t3_no_cyc", 32'(bus_cyc_o), 32'h0);
         advance();
      end
      stall = 6'd0; if_ce_i = 1'b0;
      sample(); chk("t3_last_hold", if_data_o, 32'h12345678); advance();
      sample(); chk("t3_idle_data", if_data_o, 32'h0); advance();

      // Flush during a fetch: cycle completes, result dropped, no issue under flush
      if_ce_i = 1'b1; if_addr_i = 32'h300;
      sample(); advance();
      flush = 1'b1;
      sample(); chk("t4_stall_flush", 32'(if_stallreq_o), 32'h1); advance();
      flush = 1'b0; bus_ack_i = 1'b1; bus_data_i = 32'hAAAA5555;
      sample();
      chk("t4_dropped", if_data_o, 32'h0);
      chk("t4_stall_ack", 32'(if_stallreq_o), 32'h0);
      advance();
      bus_ack_i = 1'b0; flush = 1'b1;
      sample(); chk("t4_idle_flush_stall", 32'(if_stallreq_o), 32'h0); advance();
      flush = 1'b0; if_ce_i = 1'b0;
      sample(); chk("t4_no_issue", 32'(bus_cyc_o), 32'h0); advance();

      // Load with no ack: watchdog terminates after 16 busy cycles
      mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h400;
      bus_data_i = 32'h77777777;
      sample(); advance();
      for (int i = 0; i < TO; i++) begin
         sample();
         chk("t5_cyc", 32'(bus_cyc_o), 32'h1);
         if (i == TO - 1) begin
            chk("t5_stall_fall", 32'(mem_stallreq_o), 32'h0);
            chk("t5_data_zero", mem_data_o, 32'h0);
         end else begin
            chk("t5_stall_busy", 32'(mem_stallreq_o), 32'h1);
         end
         advance();
      end
      mem_ce_i = 1'b0;
      sample();
      chk("t5_cyc_drop", 32'(bus_cyc_o), 32'h0);
      chk("t5_pulse", 32'(bus_timeout_o), 32'h1);
      advance();
      sample(); chk("t5_pulse_end", 32'(bus_timeout_o), 32'h0); advance();

      // Reset in the middle of a store; a late ack is ignored
      mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'h3; mem_addr_i = 32'h500; mem_data_i = 32'h0BADF00D;
      sample(); advance();
      rst = 1'b1;
      sample();
      chk("t6_cyc_before", 32'(bus_cyc_o), 32'h1);
      chk("t6_sel", 32'(bus_sel_o), 32'h3);
      advance();
      rst = 1'b0; mem_ce_i = 1'b0; mem_we_i = 1'b0; bus_ack_i = 1'b1;
      sample();
      chk("t6_cyc_rst", 32'(bus_cyc_o), 32'h0);
      chk("t6_stb_rst", 32'(bus_stb_o), 32'h0);
      chk("t6_sel_rst", 32'(bus_sel_o), 32'h0);
      chk("t6_mem_stall", 32'(mem_stallreq_o), 32'h0);
      advance();
      bus_ack_i = 1'b0;
      sample(); chk("t6_still_idle", 32'(bus_cyc_o), 32'h0); advance();

      // Load acked under stall, held result released by flush
      mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h600;
      sample(); advance();
      bus_ack_i = 1'b1; bus_data_i = 32'hCAFEF00D; stall = 6'b001000;
      sample(); chk("t7_bypass", mem_data_o, 32'hCAFEF00D); advance();
      bus_ack_i = 1'b0; mem_ce_i = 1'b0;
      sample();
      chk("t7_hold", mem_data_o, 32'hCAFEF00D);
      chk("t7_stall", 32'(mem_stallreq_o), 32'h0);
      advance();
      flush = 1'b1;
      sample(); advance();
      flush = 1'b0; stall = 6'd0;
      sample(); chk("t7_released", mem_data_o, 32'h0); advance();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
